// File: rtl/button_debouncer_pkg.sv
// Shared button-count and debounce constants so the SoC top and the debouncer
// agree on defaults, plus the counter sizing helper.
package button_debouncer_pkg;

  localparam int DEF_N_BUTTONS       = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_SYNC_STAGES     = 2;

  // Counter must hold 0..DEBOUNCE_CYCLES-1; sized on +1 so DEBOUNCE_CYCLES=1 still gets one bit.
  function automatic int debounce_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce_bit.sv
// One button channel: synchroniser, stability counter, accepted level and
// registered single-cycle press/release pulses.
module button_debounce_bit
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              CNT_W    = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   stable_nxt;
  logic                   press_nxt;
  logic                   release_nxt;

  // Stage boundary: asynchronous pad into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync = sync_p[SYNC_STAGES-1];

  // Any sample matching the accepted level restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
  always_comb begin
    cnt_nxt     = cnt;
    stable_nxt  = stable;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (sync == stable) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt     = '0;
      stable_nxt  = sync;
      press_nxt   = sync;
      release_nxt = ~sync;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Stage boundary: counter, accepted level and edge pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      stable        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      stable        <= stable_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Conditions raw push-button pads into clean levels plus press/release event
// pulses; every channel is an independent button_debounce_bit.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int N_BUTTONS       = DEF_N_BUTTONS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] buttons_raw_i,
  output logic [N_BUTTONS-1:0] buttons_o,
  output logic [N_BUTTONS-1:0] press_o,
  output logic [N_BUTTONS-1:0] release_o
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_bit
    button_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_bit (
      .clk          (clk),
      .rst          (rst),
      .raw          (buttons_raw_i[i]),
      .stable       (buttons_o[i]),
      .press_pulse  (press_o[i]),
      .release_pulse(release_o[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
// stimulus queues hand-computed pulse events, a monitor checks every cycle.
module tb_button_debouncer;

  localparam int NB  = 4;
  localparam int DC  = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + DC;

  typedef struct {
    int       at_edge;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] btn;
  } evt_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] buttons_raw_i = '0;
  logic [NB-1:0] buttons_o;
  logic [NB-1:0] press_o;
  logic [NB-1:0] release_o;

  evt_t q[$];
  int   edge_no = 0;
  int   checks  = 0;
  int   errors  = 0;

  button_debouncer #(
    .N_BUTTONS      (NB),
    .DEBOUNCE_CYCLES(DC),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buttons_raw_i(buttons_raw_i),
    .buttons_o    (buttons_o),
    .press_o      (press_o),
    .release_o    (release_o)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle the outputs must equal the accepted level and either
  // the queued event due on this edge or no pulse at all.
  initial begin
    evt_t       e;
    logic [3:0] exp_btn;
    logic [3:0] exp_p;
    logic [3:0] exp_r;
    exp_btn = '0;
    forever begin
      @(posedge clk);
      edge_no++;
      #1;
      exp_p = '0;
      exp_r = '0;
      if (rst) begin
        q.delete();
        exp_btn = '0;
      end else if (q.size() > 0 && q[0].at_edge == edge_no) begin
        e       = q.pop_front();
        exp_btn = e.btn;
        exp_p   = e.press;
        exp_r   = e.rel;
      end
      checks++;
      if (buttons_o !== exp_btn || press_o !== exp_p || release_o !== exp_r) begin
        errors++;
        $display("FAIL edge%0d btn/press/rel actual %h/%h/%h required %h/%h/%h",
                 edge_no, buttons_o, press_o, release_o, exp_btn, exp_p, exp_r);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge right after changing raw: event lands LAT edges later.
  task automatic expect_evt(input logic [3:0] p, input logic [3:0] r, input logic [3:0] b);
    evt_t e;
    e.at_edge = edge_no + LAT;
    e.press   = p;
    e.rel     = r;
    e.btn     = b;
    q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  initial begin
    // Power-on reset
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // Clean press on bit 0, then held for 100 cycles with no further pulses
    buttons_raw_i = 4'h1;
    expect_evt(4'h1, 4'h0, 4'h1);
    cycles(106);

    // Bounce on bit 1: 1,1,1,0 then 1 held; count restarts on the glitch
    buttons_raw_i = 4'h3;
    cycles(3);
    buttons_raw_i = 4'h1;
    cycles(1);
    buttons_raw_i = 4'h3;
    expect_evt(4'h2, 4'h0, 4'h3);
    cycles(12);

    // Press then release bit 2
    buttons_raw_i = 4'h7;
    expect_evt(4'h4, 4'h0, 4'h7);
    cycles(10);
    buttons_raw_i = 4'h3;
    expect_evt(4'h0, 4'h4, 4'h3);
    cycles(10);

    // Release bits 0 and 1 together, then simultaneous press of bits 0 and 3
    buttons_raw_i = 4'h0;
    expect_evt(4'h0, 4'h3, 4'h0);
    cycles(10);
    buttons_raw_i = 4'h9;
    expect_evt(4'h9, 4'h0, 4'h9);
    cycles(10);

    // Three-cycle pulse on bit 1 is too short to be accepted
    buttons_raw_i = 4'hB;
    cycles(3);
    buttons_raw_i = 4'h9;
    cycles(10);

    // Asynchronous reset mid-cycle with all raw inputs high
    buttons_raw_i = 4'hF;
    #2;
    rst = 1'b1;
    #1;
    check_now("async_reset", {buttons_o, press_o, release_o}, 12'h000);
    cycles(2);
    rst = 1'b0;
    expect_evt(4'hF, 4'h0, 4'hF);
    cycles(10);

    // Release everything, then reset in the middle of a bit-0 press count
    buttons_raw_i = 4'h0;
    expect_evt(4'h0, 4'hF, 4'h0);
    cycles(10);
    buttons_raw_i = 4'h1;
    cycles(3);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    expect_evt(4'h1, 4'h0, 4'h1);
    cycles(15);

    check_now("queue_drained", 12'(q.size()), 12'h000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout actual %0t required <20000", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
